display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Handshake/bus bundle for display_scan_ctrl.
//   oi        : load strobe, bus/disp_mode captured on the edge where oi=1
//   bus       : 8-bit value to display
//   disp_mode : 0 = unsigned, 1 = two's-complement signed
//   busy      : conversion in progress
//   cc        : digit select, active-low one-hot
//   seg       : segments {dp,g,f,e,d,c,b,a}, active-high
// master = producer of the value (bench / host), slave = the controller.
interface display_scan_ctrl_if;
    logic       oi;
    logic [7:0] bus;
    logic       disp_mode;
    logic       busy;
    logic [3:0] cc;
    logic [7:0] seg;

    modport master (output oi, output bus, output disp_mode,
                    input  busy, input cc, input seg);
    modport slave  (input  oi, input bus, input disp_mode,
                    output busy, output cc, output seg);
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-slot multiplexed 7-segment display controller.
// A loaded byte is converted to BCD by an 8-step double-dabble; the result
// is committed to the display registers only once complete, so a partial
// value never reaches the segments.  A free-running prescaler walks the
// digit index ones -> tens -> hundreds -> sign.
// Ports:
//   clk : system clock, all state changes on posedge
//   clr : asynchronous active-high reset
//   io  : display_scan_ctrl_if.slave (oi, bus, disp_mode, busy, cc, seg)
module display_scan_ctrl #(
    parameter int PRESCALE = 1024
) (
    input  logic                 clk,
    input  logic                 clr,
    display_scan_ctrl_if.slave   io
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state_r;
    logic          busy_r;
    logic [7:0]    mag_r;
    logic          neg_pend_r;
    logic [11:0]   bcd_r;
    logic [3:0]    cnt_r;
    logic [3:0]    hund_r;
    logic [3:0]    tens_r;
    logic [3:0]    ones_r;
    logic          neg_r;
    logic [PW-1:0] pre_r;
    logic [1:0]    idx_r;
    logic [11:0]   bcd_adj_s;
    logic [3:0]    cc_s;
    logic [7:0]    seg_s;

    // Add 3 to a BCD nibble of 5 or more before the shift.
    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        if (n >= 4'd5) begin
            nib_adj = n + 4'd3;
        end else begin
            nib_adj = n;
        end
    endfunction

    // Seven-segment pattern for one decimal digit.
    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 8'h3F;
            4'd1:    digit_seg = 8'h06;
            4'd2:    digit_seg = 8'h5B;
            4'd3:    digit_seg = 8'h4F;
            4'd4:    digit_seg = 8'h66;
            4'd5:    digit_seg = 8'h6D;
            4'd6:    digit_seg = 8'h7D;
            4'd7:    digit_seg = 8'h07;
            4'd8:    digit_seg = 8'h7F;
            4'd9:    digit_seg = 8'h6F;
            default: digit_seg = 8'h00;
        endcase
    endfunction

    assign bcd_adj_s = {nib_adj(bcd_r[11:8]), nib_adj(bcd_r[7:4]), nib_adj(bcd_r[3:0])};

    // Conversion FSM; a load in any state restarts, discarding any pending result.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            mag_r      <= 8'd0;
            neg_pend_r <= 1'b0;
            bcd_r      <= 12'd0;
            cnt_r      <= 4'd0;
            hund_r     <= 4'd0;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
            neg_r      <= 1'b0;
        end else if (io.oi) begin
            // 0x80 negates to 0x80, which read unsigned is the needed 128.
            if (io.disp_mode && io.bus[7]) begin
                mag_r      <= 8'd0 - io.bus;
                neg_pend_r <= 1'b1;
            end else begin
                mag_r      <= io.bus;
                neg_pend_r <= 1'b0;
            end
            bcd_r   <= 12'd0;
            cnt_r   <= 4'd0;
            state_r <= CONV;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                end
                CONV: begin
                    {bcd_r, mag_r} <= {bcd_adj_s[10:0], mag_r, 1'b0};
                    cnt_r          <= cnt_r + 4'd1;
                    if (cnt_r == 4'd7) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= CONV;
                    end
                end
                COMMIT: begin
                    hund_r  <= bcd_r[11:8];
                    tens_r  <= bcd_r[7:4];
                    ones_r  <= bcd_r[3:0];
                    neg_r   <= neg_pend_r;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre_r <= '0;
            idx_r <= 2'd0;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Digit select and segment decode with leading-zero blanking.
    always_comb begin
        cc_s  = 4'b1110;
        seg_s = 8'h00;
        case (idx_r)
            2'd0: begin
                cc_s  = 4'b1110;
                seg_s = digit_seg(ones_r);
            end
            2'd1: begin
                cc_s = 4'b1101;
                if ((hund_r == 4'd0) && (tens_r == 4'd0)) begin
                    seg_s = 8'h00;
                end else begin
                    seg_s = digit_seg(tens_r);
                end
            end
            2'd2: begin
                cc_s = 4'b1011;
                if (hund_r == 4'd0) begin
                    seg_s = 8'h00;
                end else begin
                    seg_s = digit_seg(hund_r);
                end
            end
            2'd3: begin
                cc_s = 4'b0111;
                if (neg_r) begin
                    seg_s = 8'h40;
                end else begin
                    seg_s = 8'h00;
                end
            end
            default: begin
                cc_s  = 4'b1110;
                seg_s = 8'h00;
            end
        endcase
    end

    assign io.busy = busy_r;
    assign io.cc   = cc_s;
    assign io.seg  = seg_s;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (PRESCALE=2).  The driver pushes the
// expected four slot patterns on each load; the monitor pops one entry on
// every busy falling edge and reads all four scan slots back.
module tb_display_scan_ctrl;

    logic clk;
    logic clr;
    int   tests;
    int   fails;
    int   cyc;
    int   load_n;

    typedef struct {
        logic [31:0] segs;   // {slot3, slot2, slot1, slot0}
        int          cyc;    // edge at which the load was captured
    } exp_t;

    exp_t q[$];

    display_scan_ctrl_if io ();

    display_scan_ctrl #(.PRESCALE(2)) dut (
        .clk (clk),
        .clr (clr),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // Reference: decimal digits by plain arithmetic, then blanking rules.
    function automatic logic [31:0] model_segs(input logic [7:0] b, input logic dm);
        int mag;
        int h;
        int t;
        int o;
        logic neg;
        logic [7:0] s0, s1, s2, s3;
        neg = dm && b[7];
        mag = neg ? (256 - int'(b)) : int'(b);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        s0 = seg_of(o);
        s1 = (h == 0 && t == 0) ? 8'h00 : seg_of(t);
        s2 = (h == 0) ? 8'h00 : seg_of(h);
        s3 = neg ? 8'h40 : 8'h00;
        return {s3, s2, s1, s0};
    endfunction

    // Collect the segment pattern of every slot over one scan round.
    task automatic capture(output logic [31:0] segs, output bit ok);
        logic [3:0] seen;
        seen = 4'd0;
        segs = 32'd0;
        for (int i = 0; i < 12; i++) begin
            case (io.cc)
                4'b1110: begin segs[7:0]   = io.seg; seen[0] = 1'b1; end
                4'b1101: begin segs[15:8]  = io.seg; seen[1] = 1'b1; end
                4'b1011: begin segs[23:16] = io.seg; seen[2] = 1'b1; end
                4'b0111: begin segs[31:24] = io.seg; seen[3] = 1'b1; end
                default: ;
            endcase
            if (seen == 4'hF) break;
            @(negedge clk);
        end
        ok = (seen == 4'hF);
    endtask

    // Load one value; with restart the still-pending result is dropped.
    task automatic load(input logic [7:0] b, input logic dm, input bit restart);
        exp_t e;
        @(posedge clk);
        #1;
        io.bus       = b;
        io.disp_mode = dm;
        io.oi        = 1'b1;
        @(posedge clk);
        #1;
        io.oi  = 1'b0;
        load_n = cyc;
        if (restart && q.size() > 0) void'(q.pop_back());
        e.segs = model_segs(b, dm);
        e.cyc  = cyc;
        q.push_back(e);
        chk("busy_after_load", {31'd0, io.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (io.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, io.busy}, 32'd0);
        repeat (12) @(negedge clk);
    endtask

    // Monitor: each completed conversion must match the oldest expectation.
    initial begin
        logic prev_busy;
        logic prev_clr;
        logic [31:0] got;
        bit ok;
        exp_t e;
        prev_busy = 1'b0;
        prev_clr  = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_busy && !io.busy && !clr && !prev_clr) begin
                if (q.size() == 0) begin
                    chk("spurious_commit", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.cyc, 32'd9);
                    capture(got, ok);
                    chk("scan_complete", {31'd0, ok}, 32'd1);
                    chk("slot0", {24'd0, got[7:0]},   {24'd0, e.segs[7:0]});
                    chk("slot1", {24'd0, got[15:8]},  {24'd0, e.segs[15:8]});
                    chk("slot2", {24'd0, got[23:16]}, {24'd0, e.segs[23:16]});
                    chk("slot3", {24'd0, got[31:24]}, {24'd0, e.segs[31:24]});
                end
            end
            prev_busy = io.busy;
            prev_clr  = clr;
        end
    end

    initial begin
        logic [31:0] got;
        bit ok;
        exp_t e;
        tests = 0;
        fails = 0;
        load_n = 0;
        clr = 1'b1;
        io.oi = 1'b0;
        io.bus = 8'd0;
        io.disp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, io.busy}, 32'd0);
        chk("rst_cc", {28'd0, io.cc}, 32'h0000_000E);
        chk("rst_seg", {24'd0, io.seg}, 32'h0000_003F);

        // Reset display across all slots.
        clr = 1'b0;
        @(negedge clk);
        capture(got, ok);
        chk("rst_display", got, 32'h0000_003F);

        // Scan order with PRESCALE=2, one load in the middle.
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("scan_cc", {28'd0, io.cc}, {28'd0, ~(4'b0001 << ((k / 2) % 4))});
            if (k == 5) begin
                io.bus = 8'h2A;
                io.disp_mode = 1'b0;
                io.oi = 1'b1;
                e.segs = model_segs(8'h2A, 1'b0);
                e.cyc  = cyc + 1;
                q.push_back(e);
            end
            if (k == 6) io.oi = 1'b0;
        end
        wait_idle();

        // Directed boundary values.
        load(8'hFF, 1'b0, 1'b0); wait_idle();
        load(8'h80, 1'b1, 1'b0); wait_idle();
        load(8'hF6, 1'b1, 1'b0); wait_idle();
        load(8'h00, 1'b1, 1'b0); wait_idle();
        load(8'h7F, 1'b1, 1'b0); wait_idle();
        load(8'h80, 1'b0, 1'b0); wait_idle();

        // Randomized values.
        for (int i = 0; i < 16; i++) begin
            load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            wait_idle();
        end

        // Restart: 0x10 at N, 0x07 at N+3; display goes 0 -> 7 at N+12.
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        fork
            begin
                load(8'h10, 1'b0, 1'b0);
                @(posedge clk);
                load(8'h07, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int k = 0; k < 14; k++) begin
                    @(negedge clk);
                    if (io.cc == 4'b1110)
                        chk("restart_ones", {24'd0, io.seg},
                            (cyc >= load_n + 9) ? 32'h07 : 32'h3F);
                    else
                        chk("restart_blank", {24'd0, io.seg}, 32'h00);
                end
            end
        join
        wait_idle();

        // Clear mid-conversion: 0x63 loaded, clr over edges N+4..N+5.
        load(8'h63, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        chk("clr_busy", {31'd0, io.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        if (q.size() > 0) void'(q.pop_back());
        repeat (20) @(negedge clk);
        chk("clr_busy_after", {31'd0, io.busy}, 32'd0);
        capture(got, ok);
        chk("clr_display", got, 32'h0000_003F);

        // Load after release behaves normally.
        load(8'h05, 1'b1, 1'b0); wait_idle();
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
